// File: rtl/alu_execute_stage.sv
// Execute stage: evaluates decoded ALU ops and registers results toward memory
// through a 2-entry skid FIFO with valid/ready handshakes on both sides.
module alu_execute_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            ALU_CONTROL,
  input  logic [XLEN-1:0]       src_a,
  input  logic [XLEN-1:0]       src_b,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic                  reg_write,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       ALU_RESULT,
  output logic                  ZERO,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_reg_write,
  output logic [1:0]            occupancy
);

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;

  typedef struct packed {
    logic [XLEN-1:0]       result;
    logic                  zero;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
  } entry_t;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  entry_t          head_q, head_d;
  entry_t          tail_q, tail_d;
  entry_t          new_entry;
  logic [XLEN-1:0] alu_out;
  logic            accept;
  logic            dequeue;

  always_comb begin
    alu_out = src_a + src_b;
    case (ALU_CONTROL)
      ALU_ADD: alu_out = src_a + src_b;
      ALU_SUB: alu_out = src_a - src_b;
      ALU_AND: alu_out = src_a & src_b;
      ALU_OR:  alu_out = src_a | src_b;
      ALU_XOR: alu_out = src_a ^ src_b;
      default: alu_out = src_a + src_b;
    endcase
  end

  // ZERO is captured alongside the result so the output path is purely registered.
  always_comb begin
    new_entry.result    = alu_out;
    new_entry.zero      = (alu_out == '0);
    new_entry.rd        = rd;
    new_entry.reg_write = reg_write;
  end

  assign in_ready      = (state_q != StFull);
  assign out_valid     = (state_q != StEmpty);
  assign occupancy     = state_q;
  assign accept        = in_valid && in_ready;
  assign dequeue       = out_valid && out_ready;
  assign ALU_RESULT    = head_q.result;
  assign ZERO          = head_q.zero;
  assign out_rd        = head_q.rd;
  assign out_reg_write = head_q.reg_write;

  // Flush only drops occupancy; payload registers hold so the outputs stay deterministic.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (accept) begin
            head_d  = new_entry;
            state_d = StOne;
          end
        end
        StOne: begin
          case ({accept, dequeue})
            2'b11: head_d = new_entry;
            2'b10: begin
              tail_d  = new_entry;
              state_d = StFull;
            end
            2'b01: state_d = StEmpty;
            default: ;
          endcase
        end
        StFull: begin
          if (dequeue) begin
            head_d  = tail_q;
            state_d = StOne;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StEmpty;
      head_q.result    <= '0;
      head_q.zero      <= 1'b1;
      head_q.rd        <= '0;
      head_q.reg_write <= 1'b0;
      tail_q.result    <= '0;
      tail_q.zero      <= 1'b1;
      tail_q.rd        <= '0;
      tail_q.reg_write <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

endmodule

// File: tb/tb_alu_execute_stage.sv
// Directed and scoreboarded checks for alu_execute_stage: reset, arithmetic,
// backpressure ordering, throughput, flush and random handshake traffic.
module tb_alu_execute_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  ALU_CONTROL;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [4:0]  rd;
  logic        reg_write;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALU_RESULT;
  logic        ZERO;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  alu_execute_stage #(
    .XLEN      (32),
    .REG_ADDR_W(5)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ALU_CONTROL  (ALU_CONTROL),
    .src_a        (src_a),
    .src_b        (src_b),
    .rd           (rd),
    .reg_write    (reg_write),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ALU_RESULT   (ALU_RESULT),
    .ZERO         (ZERO),
    .out_rd       (out_rd),
    .out_reg_write(out_reg_write),
    .occupancy    (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r, input logic w);
    in_valid    = v;
    ALU_CONTROL = c;
    src_a       = a;
    src_b       = b;
    rd          = r;
    reg_write   = w;
  endtask

  // Reference ALU: codes 000 add, 001 sub, 010 and, 011 or, 100 xor, others add.
  function automatic logic [31:0] alu_ref(input logic [2:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    case (c)
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a ^ b;
      default: return a + b;
    endcase
  endfunction

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL reset_state out_valid=%0d occupancy=%0d want 0/0", out_valid, occupancy);
    else n_pass++;
    n_checks++;
    if (ALU_RESULT !== 32'h0 || ZERO !== 1'b1)
      $display("FAIL reset_result result=%h zero=%0d want 0/1", ALU_RESULT, ZERO);
    else n_pass++;
    n_checks++;
    if (out_rd !== 5'd0 || out_reg_write !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_fields rd=%0d rw=%0d in_ready=%0d want 0/0/1",
               out_rd, out_reg_write, in_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL reset_release in_ready=%0d out_valid=%0d want 1/0", in_ready, out_valid);
    else n_pass++;
  endtask

  task automatic test_arith;
    logic [2:0]  c_t [8] = '{3'b000, 3'b001, 3'b100, 3'b111, 3'b010, 3'b011, 3'b101, 3'b001};
    logic [31:0] a_t [8] = '{32'hFFFF_FFFF, 32'd5, 32'hA5A5_A5A5, 32'd2, 32'hF0F0_FF00,
                            32'h1234_0000, 32'd10, 32'd7};
    logic [31:0] b_t [8] = '{32'd1, 32'd7, 32'hFFFF_FFFF, 32'd3, 32'h0FF0_F0F0,
                            32'h0000_5678, 32'd20, 32'd7};
    logic [31:0] r_t [8] = '{32'h0, 32'hFFFF_FFFE, 32'h5A5A_5A5A, 32'd5, 32'h00F0_F000,
                            32'h1234_5678, 32'd30, 32'h0};
    logic        z_t [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, c_t[i], a_t[i], b_t[i], 5'(i + 8), i[0]);
      step();
      n_checks++;
      if (out_valid !== 1'b1 || ALU_RESULT !== r_t[i] || ZERO !== z_t[i])
        $display("FAIL arith_%0d valid=%0d result=%h zero=%0d want 1/%h/%0d",
                 i, out_valid, ALU_RESULT, ZERO, r_t[i], z_t[i]);
      else n_pass++;
      n_checks++;
      if (out_rd !== 5'(i + 8) || out_reg_write !== i[0])
        $display("FAIL arith_fields_%0d rd=%0d rw=%0d want %0d/%0d",
                 i, out_rd, out_reg_write, i + 8, i[0]);
      else n_pass++;
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL arith_drain out_valid=%0d occupancy=%0d want 0/0", out_valid, occupancy);
    else n_pass++;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'd1, 32'd1, 5'd1, 1'b1);   // A = 2
    step();
    n_checks++;
    if (occupancy !== 2'd1 || in_ready !== 1'b1 || ALU_RESULT !== 32'd2)
      $display("FAIL bp_after_a occ=%0d in_ready=%0d result=%h want 1/1/2",
               occupancy, in_ready, ALU_RESULT);
    else n_pass++;
    drive(1'b1, 3'b001, 32'd10, 32'd3, 5'd2, 1'b0);  // B = 7
    step();
    n_checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0)
      $display("FAIL bp_full occ=%0d in_ready=%0d want 2/0", occupancy, in_ready);
    else n_pass++;
    drive(1'b1, 3'b011, 32'd8, 32'd1, 5'd3, 1'b1);   // C = 9
    step();
    n_checks++;
    if (occupancy !== 2'd2 || out_rd !== 5'd1 || ALU_RESULT !== 32'd2 || out_reg_write !== 1'b1)
      $display("FAIL bp_head_hold occ=%0d rd=%0d result=%h rw=%0d want 2/1/2/1",
               occupancy, out_rd, ALU_RESULT, out_reg_write);
    else n_pass++;
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_rd !== 5'd2 || ALU_RESULT !== 32'd7 || out_reg_write !== 1'b0)
      $display("FAIL bp_second valid=%0d rd=%0d result=%h rw=%0d want 1/2/7/0",
               out_valid, out_rd, ALU_RESULT, out_reg_write);
    else n_pass++;
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || out_rd !== 5'd3 || ALU_RESULT !== 32'd9 || occupancy !== 2'd1)
      $display("FAIL bp_third valid=%0d rd=%0d result=%h occ=%0d want 1/3/9/1",
               out_valid, out_rd, ALU_RESULT, occupancy);
    else n_pass++;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL bp_drain valid=%0d occ=%0d want 0/0", out_valid, occupancy);
    else n_pass++;
  endtask

  task automatic test_throughput;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, 3'b000, 32'(i), 32'(2 * i), 5'(i), 1'b1);
      step();
      n_checks++;
      if (out_valid !== 1'b1 || occupancy !== 2'd1 || ALU_RESULT !== 32'(3 * i)
          || out_rd !== 5'(i))
        $display("FAIL thru_%0d valid=%0d occ=%0d result=%0d rd=%0d want 1/1/%0d/%0d",
                 i, out_valid, occupancy, ALU_RESULT, out_rd, 3 * i, i % 32);
      else n_pass++;
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    step();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL thru_drain valid=%0d occ=%0d want 0/0", out_valid, occupancy);
    else n_pass++;
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'd40, 32'd2, 5'd4, 1'b1);  // X = 42
    step();
    drive(1'b1, 3'b000, 32'd50, 32'd5, 5'd5, 1'b1);  // Y = 55
    step();
    n_checks++;
    if (occupancy !== 2'd2)
      $display("FAIL flush_fill occ=%0d want 2", occupancy);
    else n_pass++;
    flush = 1'b1;
    drive(1'b1, 3'b000, 32'd60, 32'd6, 5'd6, 1'b1);  // Z, must be dropped
    step();
    flush = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    n_checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush_full occ=%0d valid=%0d in_ready=%0d want 0/0/1",
               occupancy, out_valid, in_ready);
    else n_pass++;
    n_checks++;
    if (ALU_RESULT !== 32'd42 || out_rd !== 5'd4)
      $display("FAIL flush_hold result=%0d rd=%0d want 42/4", ALU_RESULT, out_rd);
    else n_pass++;
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL flush_no_ghost valid=%0d occ=%0d want 0/0", out_valid, occupancy);
    else n_pass++;
    // Flush at occupancy 1 while in_ready=1: the presented op must still be dropped.
    out_ready = 1'b0;
    drive(1'b1, 3'b001, 32'd9, 32'd4, 5'd7, 1'b0);   // W = 5
    step();
    flush = 1'b1;
    drive(1'b1, 3'b000, 32'd70, 32'd7, 5'd8, 1'b1);  // V, must be dropped
    step();
    flush = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    n_checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || ALU_RESULT !== 32'd5)
      $display("FAIL flush_one occ=%0d valid=%0d result=%0d want 0/0/5",
               occupancy, out_valid, ALU_RESULT);
    else n_pass++;
    out_ready = 1'b1;
    step();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL flush_one_drop valid=%0d occ=%0d want 0/0", out_valid, occupancy);
    else n_pass++;
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    drive(1'b1, 3'b000, 32'd3, 32'd4, 5'd9, 1'b1);
    step();
    drive(1'b1, 3'b000, 32'd5, 32'd6, 5'd10, 1'b1);
    step();
    drive(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    n_checks++;
    if (occupancy !== 2'd2)
      $display("FAIL rst_mid_fill occ=%0d want 2", occupancy);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || ALU_RESULT !== 32'h0 || ZERO !== 1'b1)
      $display("FAIL rst_mid_async valid=%0d occ=%0d result=%h zero=%0d want 0/0/0/1",
               out_valid, occupancy, ALU_RESULT, ZERO);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || occupancy !== 2'd0)
      $display("FAIL rst_mid_release in_ready=%0d valid=%0d occ=%0d want 1/0/0",
               in_ready, out_valid, occupancy);
    else n_pass++;
  endtask

  task automatic test_random;
    exp_t        q[$];
    exp_t        e;
    int          accepted = 0;
    int          cycles   = 0;
    logic        v;
    logic        acc;
    logic        deq;
    logic [2:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  r;
    logic        w;
    while ((accepted < 1000 || q.size() > 0) && cycles < 6000) begin
      n_checks++;
      if (q.size() == 0) begin
        if (out_valid !== 1'b0 || occupancy !== 2'd0)
          $display("FAIL rand_empty cyc=%0d valid=%0d occ=%0d want 0/0",
                   cycles, out_valid, occupancy);
        else n_pass++;
      end else begin
        if (out_valid !== 1'b1 || occupancy !== 2'(q.size()) || ALU_RESULT !== q[0].res
            || ZERO !== q[0].z || out_rd !== q[0].rd || out_reg_write !== q[0].rw)
          $display("FAIL rand_head cyc=%0d occ=%0d res=%h z=%0d rd=%0d rw=%0d want %0d/%h/%0d/%0d/%0d",
                   cycles, occupancy, ALU_RESULT, ZERO, out_rd, out_reg_write,
                   q.size(), q[0].res, q[0].z, q[0].rd, q[0].rw);
        else n_pass++;
      end
      v = (accepted < 1000) && ($urandom_range(0, 3) != 0);
      c = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? a : $urandom;
      r = 5'($urandom_range(0, 31));
      w = 1'($urandom_range(0, 1));
      drive(v, c, a, b, r, w);
      out_ready = 1'($urandom_range(0, 1));
      acc = v && (q.size() < 2);
      deq = (q.size() > 0) && out_ready;
      step();
      cycles++;
      if (deq) void'(q.pop_front());
      if (acc) begin
        e.res = alu_ref(c, a, b);
        e.z   = (e.res == 32'h0);
        e.rd  = r;
        e.rw  = w;
        q.push_back(e);
        accepted++;
      end
    end
    drive(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    n_checks++;
    if (accepted != 1000 || q.size() != 0)
      $display("FAIL rand_complete accepted=%0d pending=%0d want 1000/0", accepted, q.size());
    else n_pass++;
  endtask

  initial begin
    rst_n     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);
    test_reset();
    test_arith();
    test_backpressure();
    test_throughput();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_execute_stage.md
Name: alu_execute_stage

Overview:
- Execute-stage consumer of the 3-bit ALU_CONTROL code produced by the decode-stage ALU decoder.
- Accepts decoded operations over a valid/ready handshake and evaluates them: ADD, SUB, AND, OR, XOR; any other code evaluates as ADD.
- Results are registered toward the memory stage through a 2-entry skid buffer, so the stage sustains full throughput under backpressure.
- Supports a pipeline flush for branch redirects.

Parameters:
- XLEN, 32, operand/result width
- REG_ADDR_W, 5, destination register index width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous kill of all buffered results
- in_valid  input  1  decode presents an operation
- in_ready  output  1  stage can accept this cycle
- ALU_CONTROL  input  3  operation code (shared constants ALU_ADD/SUB/AND/OR/XOR)
- src_a  input  XLEN  operand A
- src_b  input  XLEN  operand B (register or immediate, already selected)
- rd  input  REG_ADDR_W  destination register
- reg_write  input  1  destination write enable
- out_valid  output  1  result available
- out_ready  input  1  memory stage accepts
- ALU_RESULT  output  XLEN  result
- ZERO  output  1  ALU_RESULT == 0
- out_rd  output  REG_ADDR_W  forwarded rd
- out_reg_write  output  1  forwarded reg_write
- occupancy  output  2  entries held (0..2)

Behaviour:
- Reset (rst_n low, asynchronous) clears both entries:
  - out_valid=0, ALU_RESULT=0, ZERO=1, out_rd=0, out_reg_write=0, occupancy=0, in_ready=1.
  - Reset asserted mid-transfer discards everything; no partial result survives.
- Compute is combinational from the inputs:
  - ADD: src_a+src_b, modulo 2^XLEN, carry discarded.
  - SUB: src_a-src_b, two's complement wrap.
  - AND, OR, XOR: bitwise.
  - Undefined codes: ADD.
- Accept occurs when in_valid && in_ready. The computed result, ZERO, rd and reg_write are captured at that clock edge. Latency is exactly 1 cycle to out_valid when the buffer is empty.
- Buffer is a 2-entry FIFO (head = output entry, tail = skid entry).
  - Outputs always reflect the head entry.
  - Dequeue occurs when out_valid && out_ready.
- in_ready = (occupancy < 2). It is registered-derived: no combinational path from out_ready to in_ready.
- Simultaneous accept and dequeue keeps occupancy unchanged; order is strictly FIFO.
  - With occupancy 1, the new entry becomes head the following cycle.
  - With occupancy 2, accept is impossible (in_ready=0).
- State machine on occupancy:
  - EMPTY(0) -> ONE on accept.
  - ONE -> EMPTY on dequeue without accept.
  - ONE -> FULL(2) on accept without dequeue.
  - FULL -> ONE on dequeue.
- While out_valid=1 && out_ready=0, head outputs hold stable; no field may change.
- flush (synchronous, priority over accept and dequeue): next cycle occupancy=0, out_valid=0, in_ready=1. An input presented in the flush cycle is dropped. Head payload is don't-care after flush but must be deterministic: hold the previous value.
- ZERO is computed from the stored result, not recomputed at the output.

Test Plan:
- Reset: assert rst_n=0 mid-stream with occupancy 2 -> asynchronously out_valid=0, occupancy=0, ALU_RESULT=0, ZERO=1. Release -> in_ready=1.
- Arithmetic, out_ready=1:
  - ADD 0xFFFFFFFF+1 -> ALU_RESULT=0, ZERO=1 one cycle later.
  - SUB 5-7 -> 0xFFFFFFFE, ZERO=0.
  - XOR 0xA5A5A5A5^0xFFFFFFFF -> 0x5A5A5A5A.
  - Code 3'b111 with 2,3 -> 5.
- Backpressure: out_ready=0, issue ops A(rd=1), B(rd=2), C(rd=3) back-to-back -> A, B accepted, in_ready=0 on third cycle, head holds A. Raise out_ready -> A, B, C emerge in order, one per cycle, no loss or duplicate.
- Throughput: out_ready=1, in_valid=1 for 100 cycles with incrementing operands -> 100 results, out_valid high continuously after cycle 1, occupancy never exceeds 1.
- Flush: occupancy=2 plus in_valid=1 in the flush cycle -> next cycle occupancy=0, out_valid=0; the flushed-cycle input never appears.
- Simultaneous accept/dequeue at occupancy 1 with out_ready toggling randomly (1000 ops) -> scoreboard matches, reg_write/rd fields preserved.
